// File: rtl/key_expand_iter_pkg.sv
// key_expand_iter_pkg
// Shared AES-128 definitions for the iterative key expander and any
// neighbouring datapath stages (round count, key width, Rcon table,
// FSM state encoding and small word helpers).
package key_expand_iter_pkg;

  localparam int AES_NR = 10;  // rounds for AES-128
  localparam int AES_NK = 4;   // 32-bit words per cipher key

  typedef logic [31:0]           aes_word_t;
  typedef logic [32*AES_NK-1:0]  aes_block_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } kx_state_t;

  localparam logic [7:0] RCON [AES_NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant byte for round rnd (1..AES_NR); zero outside that range.
  function automatic logic [7:0] rcon_byte(input logic [3:0] rnd);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < AES_NR; i++) begin
      if (rnd == 4'(i + 1)) r = RCON[i];
    end
    return r;
  endfunction

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/key_expand_iter_sbox.sv
// aes_sbox
// Combinational AES forward S-box, one byte in, one byte out. Shared by the
// key expander (SubWord) and usable unchanged by a SubBytes stage.
//   i_byte : input byte
//   o_byte : substituted byte
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/key_expand_iter.sv
// key_expand_iter
// Iterative AES-128 key expander: one round key per clock, streamed out and
// also kept in an 11-entry store for random-access reads.
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_start, i_key  : start request and cipher key (sampled in IDLE only)
//   i_rd_round      : random-access read index into the key store
//   o_busy          : expansion in progress
//   o_rk_valid      : streamed key valid (one cycle per key)
//   o_rk_round      : index of the streamed key
//   o_rk            : streamed round key
//   o_done          : pulse with the round-10 key
//   o_keys_ready    : all 11 stored keys are valid
//   o_rd_key        : stored key selected by i_rd_round (zero for 11..15)
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for i_start; round-0 key is loaded on acceptance
// ST_EXPAND | deriving rk[rnd_q] from the previous key, one per cycle
module key_expand_iter
  import key_expand_iter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [127:0]     i_key,
  input  logic [3:0]       i_rd_round,
  output logic             o_busy,
  output logic             o_rk_valid,
  output logic [3:0]       o_rk_round,
  output logic [127:0]     o_rk,
  output logic             o_done,
  output logic             o_keys_ready,
  output logic [127:0]     o_rd_key
);

  localparam int NKEYS = AES_NR + 1;

  kx_state_t  state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  aes_block_t rk_out_q, rk_out_d;
  logic [3:0] rk_round_q, rk_round_d;
  logic       rk_valid_q, rk_valid_d;
  logic       done_q, done_d;
  logic       keys_ready_q, keys_ready_d;
  aes_block_t rk_mem_q [NKEYS];
  aes_block_t rk_mem_d [NKEYS];

  // The streamed output register always holds rk[rnd_q-1] while expanding,
  // so it doubles as the working key for the next round.
  aes_word_t  w0, w1, w2, w3;
  aes_word_t  rot_w3, sub_w3, temp_w;
  aes_word_t  nw0, nw1, nw2, nw3;
  aes_block_t next_key;

  assign w0 = rk_out_q[127:96];
  assign w1 = rk_out_q[95:64];
  assign w2 = rk_out_q[63:32];
  assign w3 = rk_out_q[31:0];

  assign rot_w3 = rot_word(w3);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (rot_w3[31-8*g -: 8]),
      .o_byte (sub_w3[31-8*g -: 8])
    );
  end

  assign temp_w   = sub_w3 ^ {rcon_byte(rnd_q), 24'h000000};
  assign nw0      = w0 ^ temp_w;
  assign nw1      = w1 ^ nw0;
  assign nw2      = w2 ^ nw1;
  assign nw3      = w3 ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    rk_out_d     = rk_out_q;
    rk_round_d   = rk_round_q;
    rk_valid_d   = 1'b0;
    done_d       = 1'b0;
    keys_ready_d = keys_ready_q;
    for (int i = 0; i < NKEYS; i++) rk_mem_d[i] = rk_mem_q[i];

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d      = ST_EXPAND;
          rnd_d        = 4'd1;
          rk_out_d     = i_key;
          rk_round_d   = 4'd0;
          rk_valid_d   = 1'b1;
          keys_ready_d = 1'b0;
          rk_mem_d[0]  = i_key;
        end
      end
      ST_EXPAND: begin
        rk_out_d   = next_key;
        rk_round_d = rnd_q;
        rk_valid_d = 1'b1;
        for (int i = 1; i < NKEYS; i++) begin
          if (rnd_q == 4'(i)) rk_mem_d[i] = next_key;
        end
        if (rnd_q == 4'(AES_NR)) begin
          state_d      = ST_IDLE;
          rnd_d        = 4'd0;
          done_d       = 1'b1;
          keys_ready_d = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      rnd_q        <= 4'd0;
      rk_out_q     <= '0;
      rk_round_q   <= 4'd0;
      rk_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      for (int i = 0; i < NKEYS; i++) rk_mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      rk_out_q     <= rk_out_d;
      rk_round_q   <= rk_round_d;
      rk_valid_q   <= rk_valid_d;
      done_q       <= done_d;
      keys_ready_q <= keys_ready_d;
      for (int i = 0; i < NKEYS; i++) rk_mem_q[i] <= rk_mem_d[i];
    end
  end

  assign o_busy       = (state_q == ST_EXPAND);
  assign o_rk_valid   = rk_valid_q;
  assign o_rk_round   = rk_round_q;
  assign o_rk         = rk_out_q;
  assign o_done       = done_q;
  assign o_keys_ready = keys_ready_q;
  assign o_rd_key     = (i_rd_round <= 4'(AES_NR)) ? rk_mem_q[i_rd_round] : '0;

endmodule

// File: tb/tb_key_expand_iter.sv
module tb_key_expand_iter;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  logic [127:0] i_key = '0;
  logic [3:0]   i_rd_round = 4'd0;
  logic         o_busy, o_rk_valid, o_done, o_keys_ready;
  logic [3:0]   o_rk_round;
  logic [127:0] o_rk, o_rd_key;

  int n_assert = 0;
  int n_fail   = 0;

  key_expand_iter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_key        (i_key),
    .i_rd_round   (i_rd_round),
    .o_busy       (o_busy),
    .o_rk_valid   (o_rk_valid),
    .o_rk_round   (o_rk_round),
    .o_rk         (o_rk),
    .o_done       (o_done),
    .o_keys_ready (o_keys_ready),
    .o_rd_key     (o_rd_key)
  );

  always #5 i_clk = ~i_clk;

  // FIPS-197 appendix A.1 expansion of 2b7e1516...
  logic [127:0] a1_exp [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  // All-zero key: only rounds 0, 1 and 10 are checked (mask below).
  logic [127:0] z_exp [11] = '{
    128'h0, 128'h62636363626363636263636362636363, 128'h0, 128'h0, 128'h0,
    128'h0, 128'h0, 128'h0, 128'h0, 128'h0,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };
  logic [127:0] zeros [11] = '{default: 128'h0};
  localparam logic [10:0] ALL_MASK = 11'h7ff;
  localparam logic [10:0] Z_MASK   = 11'b100_0000_0011;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic kick(input logic [127:0] key);
    i_key   = key;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Called one cycle after the accepting edge; samples 11 streamed keys.
  task automatic stream_check(input string nm, input logic [127:0] exp [11],
                              input logic [10:0] mask, input int pulse_at,
                              input logic [127:0] pulse_key, input bit tail);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("%s valid[%0d]", nm, i), 128'(o_rk_valid), 128'(1'b1));
      chk($sformatf("%s round[%0d]", nm, i), 128'(o_rk_round), 128'(i));
      if (mask[i]) chk($sformatf("%s rk[%0d]", nm, i), o_rk, exp[i]);
      chk($sformatf("%s done[%0d]", nm, i), 128'(o_done), 128'(i == 10));
      chk($sformatf("%s busy[%0d]", nm, i), 128'(o_busy), 128'(i != 10));
      chk($sformatf("%s ready[%0d]", nm, i), 128'(o_keys_ready), 128'(i == 10));
      if (i == pulse_at) begin
        i_key   = pulse_key;
        i_start = 1'b1;
      end
      if (i < 10 || tail) step();
      if (i == pulse_at) i_start = 1'b0;
    end
    if (tail) begin
      chk({nm, " tail valid"}, 128'(o_rk_valid), 128'(1'b0));
      chk({nm, " tail round hold"}, 128'(o_rk_round), 128'(4'd10));
      if (mask[10]) chk({nm, " tail rk hold"}, o_rk, exp[10]);
      chk({nm, " tail done"}, 128'(o_done), 128'(1'b0));
      chk({nm, " tail busy"}, 128'(o_busy), 128'(1'b0));
      chk({nm, " tail ready"}, 128'(o_keys_ready), 128'(1'b1));
    end
  endtask

  task automatic sweep(input string nm, input logic [127:0] exp [11], input logic [10:0] mask);
    for (int r = 0; r < 16; r++) begin
      i_rd_round = 4'(r);
      #1;
      if (r > 10) chk($sformatf("%s rd[%0d]", nm, r), o_rd_key, 128'h0);
      else if (mask[r]) chk($sformatf("%s rd[%0d]", nm, r), o_rd_key, exp[r]);
    end
    i_rd_round = 4'd0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst valid", 128'(o_rk_valid), 128'(1'b0));
    chk("rst busy", 128'(o_busy), 128'(1'b0));
    chk("rst done", 128'(o_done), 128'(1'b0));
    chk("rst ready", 128'(o_keys_ready), 128'(1'b0));
    chk("rst rk", o_rk, 128'h0);
    chk("rst round", 128'(o_rk_round), 128'h0);
    step();
    step();
    i_rst = 1'b0;
    step();
    chk("idle valid", 128'(o_rk_valid), 128'(1'b0));

    // FIPS-197 A.1 key, single-cycle start
    kick(a1_exp[0]);
    stream_check("a1", a1_exp, ALL_MASK, -1, 128'h0, 1'b1);
    sweep("a1", a1_exp, ALL_MASK);

    // All-zero key
    kick(128'h0);
    stream_check("zero", z_exp, Z_MASK, -1, 128'h0, 1'b1);
    sweep("zero", z_exp, Z_MASK);

    // Start pulsed with a different key at round 5 must be ignored
    kick(a1_exp[0]);
    stream_check("ign", a1_exp, ALL_MASK, 5, 128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    sweep("ign", a1_exp, ALL_MASK);
    step();
    chk("ign no restart", 128'(o_busy), 128'(1'b0));

    // Reset asserted at round 6
    kick(128'h0);
    for (int i = 0; i < 6; i++) step();
    chk("mid round6", 128'(o_rk_round), 128'(4'd6));
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst valid", 128'(o_rk_valid), 128'(1'b0));
    chk("arst busy", 128'(o_busy), 128'(1'b0));
    chk("arst done", 128'(o_done), 128'(1'b0));
    chk("arst rk", o_rk, 128'h0);
    chk("arst round", 128'(o_rk_round), 128'h0);
    chk("arst ready", 128'(o_keys_ready), 128'(1'b0));
    sweep("arst", zeros, ALL_MASK);
    step();
    chk("arst held done", 128'(o_done), 128'(1'b0));
    i_rst = 1'b0;
    step();
    chk("post rst valid", 128'(o_rk_valid), 128'(1'b0));
    kick(128'h0);
    stream_check("rerun", z_exp, Z_MASK, -1, 128'h0, 1'b1);

    // Start held high: back-to-back runs
    i_key   = a1_exp[0];
    i_start = 1'b1;
    step();
    stream_check("b2b1", a1_exp, ALL_MASK, -1, 128'h0, 1'b0);
    step();
    chk("b2b2 valid", 128'(o_rk_valid), 128'(1'b1));
    chk("b2b2 round", 128'(o_rk_round), 128'(4'd0));
    chk("b2b2 rk", o_rk, a1_exp[0]);
    chk("b2b2 busy", 128'(o_busy), 128'(1'b1));
    chk("b2b2 ready", 128'(o_keys_ready), 128'(1'b0));
    i_start = 1'b0;
    step();
    chk("b2b2 rk1", o_rk, a1_exp[1]);
    for (int i = 0; i < 11; i++) step();
    chk("b2b2 end busy", 128'(o_busy), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expand_iter.md
KEY_EXPAND_ITER -- requirements
Module: key_expand_iter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Port i_clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port i_rst, input, 1 bit: asynchronous active-high reset.
REQ-004 Port i_start, input, 1 bit: request to expand a new cipher key; sampled only in IDLE.
REQ-005 Port i_key, input, 128 bits: AES-128 cipher key, big-endian byte 0 at [127:120]; sampled with an accepted i_start.
REQ-006 Port i_rd_round, input, 4 bits: random-access read index, 0..10.
REQ-007 Port o_busy, output, 1 bit: high while expansion is in progress.
REQ-008 Port o_rk_valid, output, 1 bit: high for exactly one cycle per streamed round key.
REQ-009 Port o_rk_round, output, 4 bits: index of the streamed key.
REQ-010 Port o_rk, output, 128 bits: streamed round key, directly consumable as the key operand of the round-key XOR stage.
REQ-011 Port o_done, output, 1 bit: one-cycle pulse when the round-10 key is presented.
REQ-012 Port o_keys_ready, output, 1 bit: high when all 11 stored keys are valid.
REQ-013 Port o_rd_key, output, 128 bits: stored round key selected by i_rd_round.

Function
REQ-014 FSM states SHALL be IDLE and EXPAND only.
REQ-015 IDLE to EXPAND transition SHALL occur at the edge where state is IDLE and i_start is 1 (edge T0).
- At T0: store rk[0] = i_key; drive o_rk = i_key, o_rk_round = 0, o_rk_valid = 1; clear o_keys_ready; round counter = 1.
REQ-016 In EXPAND, at each edge Tn (n = 1..10), the block SHALL compute rk[n] from rk[n-1], store it, and drive o_rk = rk[n], o_rk_round = n, o_rk_valid = 1.
REQ-017 Expansion SHALL follow FIPS-197 for AES-128.
- temp = SubWord(RotWord(w3)) xor Rcon[n].
- w0' = w0 xor temp; wi' = wi xor w(i-1)'.
- Rcon = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36 in the top byte.
REQ-018 At T10 the block SHALL return to IDLE, pulse o_done for that cycle, and set o_keys_ready = 1.
REQ-019 Streamed-output latency SHALL be as follows.
- Round-0 key: valid the cycle after the i_start edge.
- Round-10 key: valid 10 cycles later.
- o_rk_valid: high for 11 consecutive cycles per run.
REQ-020 o_busy SHALL be 1 from edge T0 up to edge T10 and 0 otherwise.
REQ-021 i_start SHALL be ignored while in EXPAND (no restart, no key resample).
REQ-022 i_start held high in IDLE SHALL start a new run at the first IDLE edge, including the edge immediately after T10.
REQ-023 o_rd_key SHALL be combinational from storage.
- i_rd_round in 11..15: return all zeros.
- During EXPAND: return the new value for entries already written, stale values otherwise.
REQ-024 When o_rk_valid is 0, o_rk and o_rk_round SHALL hold their last values.

Reset
REQ-025 When i_rst is asserted, the block SHALL asynchronously force the following, including mid-expansion with no partial o_done.
- State = IDLE; round counter = 0.
- o_busy = 0, o_rk_valid = 0, o_done = 0, o_keys_ready = 0.
- o_rk = 0, o_rk_round = 0.
- All 11 stored keys = 0.
REQ-026 After reset deassertion, the first accepted i_start SHALL behave exactly as REQ-015.

Structure
REQ-027 A shared package SHALL hold the following.
- AES_NR = 10 and AES_NK = 4 constants.
- The Rcon table.
- The 128-bit state/key type.
- The FSM state enum.
REQ-028 One sub-module aes_sbox (8-bit combinational S-box) SHALL be instantiated 4 times for SubWord, and SHALL be reusable by the SubBytes stage.

Verification
REQ-029 The bench SHALL cover the following directed scenarios.
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, i_start for 1 cycle -> o_rk_round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; o_done coincident with round 10; 11 valid cycles.
- After the above, sweep i_rd_round 0..15 -> entries 0..10 match the stream; 11..15 = 0.
- Key all zeros -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- i_start pulsed with a different key at round 5 -> ignored; stream and stored keys unchanged.
- i_rst asserted at round 6 -> all outputs 0 asynchronously, no o_done; restart produces correct keys.
- i_start held high continuously -> back-to-back runs; second round-0 valid the cycle after o_done.
